cpu_ctrl_seq: RTL and testbench

- Multi-cycle control sequencer for the 8-bit accumulator CPU.
- Sits directly upstream of the ALU and drives its alu_pass/alu_add selects.
- Also drives IR, PC and accumulator load strobes, the address-mux select, and the shared-memory read/write handshake.
- Datapath convention: ALU a = memory data, b = accumulator. LDA uses pass, ADD uses add; the result loads the accumulator.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/mem_wait_timer.sv | 40 ++++
 rtl/cpu_ctrl_seq.sv | 144 ++++++++++++++
 tb/tb_cpu_ctrl_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the accumulator-CPU control sequencer.
package cpu_pkg;

   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 8;

   localparam logic [2:0] OP_HLT = 3'b000;
   localparam logic [2:0] OP_SKZ = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_LDA = 3'b011;
   localparam logic [2:0] OP_STO = 3'b100;
   localparam logic [2:0] OP_JMP = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_OPERAND,
      ST_STORE,
      ST_HALT
   } state_t;

   // States that own an outstanding memory request.
   function automatic logic is_mem_state(input state_t s);
      return (s == ST_FETCH) || (s == ST_OPERAND) || (s == ST_STORE);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of one memory access and flags the
// cycle in which the wait limit is reached.
module mem_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic timeout_o
);

   localparam logic [7:0] LIMIT_M1 = 8'(MEM_TIMEOUT - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   // Next count: clear has priority over counting.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Counter register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Fires on the wait cycle that would bring the count up to the limit.
   assign timeout_o = en_i && (cnt_q == LIMIT_M1);

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle control sequencer: fetch/decode/operand/store with a
// memory handshake, wait timeout and sticky bus fault.
module cpu_ctrl_seq
   import cpu_pkg::*;
#(
   parameter int unsigned OPC_W       = 3,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [OPC_W-1:0] opcode,
   input  logic             acc_zero,
   input  logic             mem_ready,
   input  logic             run,
   output logic             sel_pc,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             ld_ir,
   output logic             inc_pc,
   output logic             ld_pc,
   output logic             ld_acc,
   output logic             alu_pass,
   output logic             alu_add,
   output logic             halted,
   output logic             bus_fault
);

   state_t     state_q;
   state_t     state_d;
   logic       bus_fault_q;
   logic       bus_fault_d;
   logic       wait_en;
   logic       timeout;
   logic [2:0] op;

   assign op = opcode[2:0];

   // Counter only advances while a request is pending and unanswered;
   // every other cycle clears it, so each access starts from zero.
   assign wait_en = is_mem_state(state_q) && !mem_ready;

   mem_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_timer (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .clr_i    (!wait_en),
      .en_i     (wait_en),
      .timeout_o(timeout)
   );

   // State and sticky fault registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         bus_fault_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bus_fault_q <= bus_fault_d;
      end
   end

   // Next-state and strobe decode; mem_ready completion beats timeout.
   always_comb begin
      state_d     = state_q;
      bus_fault_d = bus_fault_q;
      sel_pc      = 1'b0;
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      ld_ir       = 1'b0;
      inc_pc      = 1'b0;
      ld_pc       = 1'b0;
      ld_acc      = 1'b0;
      alu_pass    = 1'b0;
      alu_add     = 1'b0;
      halted      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            sel_pc = 1'b1;
            mem_rd = 1'b1;
            if (mem_ready) begin
               ld_ir   = 1'b1;
               inc_pc  = 1'b1;
               state_d = ST_DECODE;
            end else if (timeout) begin
               bus_fault_d = 1'b1;
               state_d     = ST_HALT;
            end
         end
         ST_DECODE: begin
            case (op)
               OP_HLT: state_d = ST_HALT;
               OP_JMP: begin
                  ld_pc   = 1'b1;
                  state_d = ST_FETCH;
               end
               OP_SKZ: begin
                  inc_pc  = acc_zero;
                  state_d = ST_FETCH;
               end
               OP_ADD, OP_LDA: state_d = ST_OPERAND;
               OP_STO:         state_d = ST_STORE;
               default:        state_d = ST_FETCH;
            endcase
         end
         ST_OPERAND: begin
            mem_rd   = 1'b1;
            alu_add  = (op == OP_ADD);
            alu_pass = (op == OP_LDA);
            if (mem_ready) begin
               ld_acc  = 1'b1;
               state_d = ST_FETCH;
            end else if (timeout) begin
               bus_fault_d = 1'b1;
               state_d     = ST_HALT;
            end
         end
         ST_STORE: begin
            mem_wr = 1'b1;
            if (mem_ready) begin
               state_d = ST_FETCH;
            end else if (timeout) begin
               bus_fault_d = 1'b1;
               state_d     = ST_HALT;
            end
         end
         ST_HALT: begin
            halted = 1'b1;
            if (run && !bus_fault_q) begin
               state_d = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus_fault = bus_fault_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Scoreboard bench: instruction-level stimulus generator pushes the
// expected per-cycle strobe vector; a negedge monitor pops and compares.
module tb_cpu_ctrl_seq;

   localparam int unsigned TMO = 15;
   localparam logic [2:0] HLT = 3'b000;
   localparam logic [2:0] SKZ = 3'b001;
   localparam logic [2:0] ADD = 3'b010;
   localparam logic [2:0] LDA = 3'b011;
   localparam logic [2:0] STO = 3'b100;
   localparam logic [2:0] JMP = 3'b101;

   localparam int unsigned K_FETCH = 0;
   localparam int unsigned K_OPER  = 1;
   localparam int unsigned K_STORE = 2;
   localparam int unsigned K_DEC   = 3;
   localparam int unsigned K_HALT  = 4;
   localparam int unsigned K_RST   = 5;
   localparam int unsigned K_IDLE  = 6;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] opcode = 3'b000;
   logic       acc_zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       run = 1'b0;
   logic       sel_pc, mem_rd, mem_wr, ld_ir, inc_pc, ld_pc, ld_acc;
   logic       alu_pass, alu_add, halted, bus_fault;

   cpu_ctrl_seq #(
      .OPC_W      (3),
      .MEM_TIMEOUT(TMO)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .opcode   (opcode),
      .acc_zero (acc_zero),
      .mem_ready(mem_ready),
      .run      (run),
      .sel_pc   (sel_pc),
      .mem_rd   (mem_rd),
      .mem_wr   (mem_wr),
      .ld_ir    (ld_ir),
      .inc_pc   (inc_pc),
      .ld_pc    (ld_pc),
      .ld_acc   (ld_acc),
      .alu_pass (alu_pass),
      .alu_add  (alu_add),
      .halted   (halted),
      .bus_fault(bus_fault)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic sel_pc;
      logic mem_rd;
      logic mem_wr;
      logic ld_ir;
      logic inc_pc;
      logic ld_pc;
      logic ld_acc;
      logic alu_pass;
      logic alu_add;
      logic halted;
      logic bus_fault;
   } outv_t;

   typedef struct {
      bit          care;
      outv_t       v;
      int unsigned tag;
      int unsigned cyc;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   int unsigned cyc    = 0;
   logic [2:0]  ir     = 3'b000;
   bit          faulted = 1'b0;
   outv_t       act;

   assign act = {sel_pc, mem_rd, mem_wr, ld_ir, inc_pc, ld_pc, ld_acc,
                 alu_pass, alu_add, halted, bus_fault};

   function automatic string tag_name(input int unsigned t);
      case (t)
         K_FETCH: return "fetch";
         K_OPER:  return "operand";
         K_STORE: return "store";
         K_DEC:   return "decode";
         K_HALT:  return "halt";
         K_RST:   return "reset";
         default: return "idle";
      endcase
   endfunction

   function automatic bit rbit();
      return bit'($urandom_range(1));
   endfunction

   // Stray run pulses outside HALT must have no effect.
   function automatic bit rnd_run();
      return ($urandom_range(7) == 0);
   endfunction

   function automatic int unsigned rnd_wait();
      int unsigned r;
      r = $urandom_range(99);
      if (r < 60) return 0;
      if (r < 85) return $urandom_range(4, 1);
      if (r < 95) return TMO - 1;
      return TMO;
   endfunction

   // Strobes seen during a memory access phase.
   function automatic outv_t req_v(input int unsigned kind, input logic [2:0] op,
                                   input bit done);
      outv_t v;
      v = '0;
      if (kind == K_FETCH) begin
         v.sel_pc = 1'b1;
         v.mem_rd = 1'b1;
         v.ld_ir  = done;
         v.inc_pc = done;
      end else if (kind == K_OPER) begin
         v.mem_rd   = 1'b1;
         v.alu_add  = (op == ADD);
         v.alu_pass = (op == LDA);
         v.ld_acc   = done;
      end else begin
         v.mem_wr = 1'b1;
      end
      return v;
   endfunction

   // Drive one cycle of inputs and post its expected outputs.
   task automatic step(input bit rst, input bit rdy, input bit rn, input bit az,
                       input bit care, input outv_t v, input int unsigned tag);
      exp_t e;
      rst_n     = rst;
      mem_ready = rdy;
      run       = rn;
      acc_zero  = az;
      opcode    = ir;
      e.care = care;
      e.v    = v;
      e.tag  = tag;
      e.cyc  = cyc;
      sb.push_back(e);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic reset_seq(input int unsigned n);
      step(1'b0, rbit(), rbit(), rbit(), 1'b0, '0, K_RST);
      faulted = 1'b0;
      for (int unsigned i = 1; i < n; i++)
         step(1'b0, rbit(), rbit(), rbit(), 1'b1, '0, K_RST);
      step(1'b1, rbit(), rbit(), rbit(), 1'b1, '0, K_IDLE);
   endtask

   // One memory access: w not-ready cycles then completion, or a fault
   // once TMO consecutive not-ready cycles have elapsed.
   task automatic access(input int unsigned kind, input int unsigned w, output bit flt);
      flt = 1'b0;
      for (int unsigned i = 0; i < w && i < TMO; i++)
         step(1'b1, 1'b0, rnd_run(), rbit(), 1'b1, req_v(kind, ir, 1'b0), kind);
      if (w >= TMO) begin
         flt     = 1'b1;
         faulted = 1'b1;
      end else begin
         step(1'b1, 1'b1, rnd_run(), rbit(), 1'b1, req_v(kind, ir, 1'b1), kind);
      end
   endtask

   task automatic fault_recover();
      outv_t hv;
      hv = '0;
      hv.halted    = 1'b1;
      hv.bus_fault = 1'b1;
      step(1'b1, rbit(), 1'b1, rbit(), 1'b1, hv, K_HALT);
      for (int unsigned i = 0; i < 3; i++)
         step(1'b1, rbit(), rbit(), rbit(), 1'b1, hv, K_HALT);
      reset_seq(2);
   endtask

   // az_sel: 0/1 forces acc_zero in DECODE, 2 randomises it.
   task automatic instr(input logic [2:0] op, input int unsigned wf, input int unsigned wo,
                        input int unsigned hold, input int unsigned az_sel);
      bit    f;
      bit    az;
      outv_t dv;
      outv_t hv;
      access(K_FETCH, wf, f);
      if (f) begin
         fault_recover();
         return;
      end
      ir = op;
      az = (az_sel == 2) ? rbit() : bit'(az_sel);
      dv = '0;
      dv.ld_pc  = (op == JMP);
      dv.inc_pc = (op == SKZ) && az;
      step(1'b1, rbit(), rnd_run(), az, 1'b1, dv, K_DEC);
      f = 1'b0;
      if (op == HLT) begin
         hv = '0;
         hv.halted = 1'b1;
         for (int unsigned i = 0; i < hold; i++)
            step(1'b1, rbit(), 1'b0, rbit(), 1'b1, hv, K_HALT);
         step(1'b1, rbit(), 1'b1, rbit(), 1'b1, hv, K_HALT);
      end else if (op == ADD || op == LDA) begin
         access(K_OPER, wo, f);
      end else if (op == STO) begin
         access(K_STORE, wo, f);
      end
      if (f) fault_recover();
   endtask

   task automatic store_abort(input int unsigned k);
      bit f;
      access(K_FETCH, 0, f);
      ir = STO;
      step(1'b1, rbit(), rnd_run(), rbit(), 1'b1, '0, K_DEC);
      for (int unsigned i = 0; i < k; i++)
         step(1'b1, 1'b0, rnd_run(), rbit(), 1'b1, req_v(K_STORE, ir, 1'b0), K_STORE);
      reset_seq(2);
   endtask

   // Monitor: pop one expectation per cycle and compare mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.care) begin
            n_chk++;
            if (act === e.v) n_pass++;
            else $display("FAIL %s cyc=%0d got=%b exp=%b",
                          tag_name(e.tag), e.cyc, act, e.v);
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk);
      #1;
      reset_seq(3);
      instr(LDA, 0, 0, 0, 2);
      instr(ADD, 0, 3, 0, 2);
      instr(SKZ, 0, 0, 0, 1);
      instr(SKZ, 0, 0, 0, 0);
      instr(STO, 1, 2, 0, 2);
      instr(JMP, 0, 0, 0, 2);
      instr(HLT, 0, 0, 3, 2);
      instr(3'b110, 0, 0, 0, 2);
      instr(3'b111, 2, 0, 0, 2);
      instr(ADD, TMO - 1, TMO - 1, 0, 2);
      instr(STO, 0, TMO - 1, 0, 2);
      instr(LDA, TMO, 0, 0, 2);
      instr(ADD, 0, TMO, 0, 2);
      instr(STO, 0, TMO, 0, 2);
      store_abort(0);
      store_abort(3);
      for (int unsigned n = 0; n < 400; n++) begin
         if ($urandom_range(39) == 0)
            store_abort($urandom_range(TMO - 1));
         else
            instr(3'($urandom_range(7)), rnd_wait(), rnd_wait(), $urandom_range(3), 2);
      end
      @(negedge clk);
      #1;
      n_chk++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL drain got=%0d exp=0", sb.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
